// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search datapath: scheduler states,
// S-memory owner encoding and sizing constants used by the phase blocks.
package rc4_pkg;

  localparam int KEY_W   = 24;
  localparam int MSG_LEN = 32;
  localparam int S_DEPTH = 256;

  typedef enum logic [3:0] {
    IDLE,
    INIT_GO,
    INIT_WAIT,
    KSA_GO,
    KSA_WAIT,
    PRGA_GO,
    PRGA_WAIT,
    CHECK,
    NEXT_KEY,
    FOUND,
    FAIL
  } sched_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INIT = 2'd1,
    OWN_KSA  = 2'd2,
    OWN_PRGA = 2'd3
  } mem_owner_t;

  // Each phase owns the S memory from its GO cycle through its WAIT state.
  function automatic mem_owner_t owner_of(input sched_state_t s);
    case (s)
      INIT_GO, INIT_WAIT: return OWN_INIT;
      KSA_GO, KSA_WAIT:   return OWN_KSA;
      PRGA_GO, PRGA_WAIT: return OWN_PRGA;
      default:            return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc4_phase_sched_s_mem_port_mux.sv
// 3:1 S-memory request mux; with no owner selected the memory sees a quiet,
// all-zero request so stray writes cannot land.
module s_mem_port_mux
  import rc4_pkg::*;
(
  input  logic [1:0] i_sel,
  input  logic [7:0] i_init_addr,
  input  logic [7:0] i_init_data,
  input  logic       i_init_wren,
  input  logic [7:0] i_ksa_addr,
  input  logic [7:0] i_ksa_data,
  input  logic       i_ksa_wren,
  input  logic [7:0] i_prga_addr,
  input  logic [7:0] i_prga_data,
  input  logic       i_prga_wren,
  output logic [7:0] o_addr,
  output logic [7:0] o_data,
  output logic       o_wren
);

  always_comb begin
    o_addr = '0;
    o_data = '0;
    o_wren = 1'b0;
    case (i_sel)
      OWN_INIT: begin
        o_addr = i_init_addr;
        o_data = i_init_data;
        o_wren = i_init_wren;
      end
      OWN_KSA: begin
        o_addr = i_ksa_addr;
        o_data = i_ksa_data;
        o_wren = i_ksa_wren;
      end
      OWN_PRGA: begin
        o_addr = i_prga_addr;
        o_data = i_prga_data;
        o_wren = i_prga_wren;
      end
      default: begin
        o_addr = '0;
        o_data = '0;
        o_wren = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rc4_phase_sched.sv
// Sequences S-init, key schedule and PRGA for each candidate key, walking the
// key upward until the checker accepts a plaintext or the key space runs out.
module rc4_phase_sched #(
  parameter int                KEY_W    = rc4_pkg::KEY_W,
  parameter logic [KEY_W-1:0]  KEY_LAST = 24'h3FFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_start,
  output logic             init_start,
  output logic             ksa_start,
  output logic             prga_start,
  input  logic             init_done,
  input  logic             ksa_done,
  input  logic             prga_done,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       init_data,
  input  logic             init_wren,
  input  logic [7:0]       ksa_addr,
  input  logic [7:0]       ksa_data,
  input  logic             ksa_wren,
  input  logic [7:0]       prga_addr,
  input  logic [7:0]       prga_data,
  input  logic             prga_wren,
  output logic [7:0]       mem_address,
  output logic [7:0]       mem_data,
  output logic             wren,
  input  logic             msg_ok,
  output logic [KEY_W-1:0] secret_key,
  output logic             busy,
  output logic             found,
  output logic             fail
);

  import rc4_pkg::*;

  sched_state_t     r_state;
  sched_state_t     w_next;
  logic [KEY_W-1:0] r_key;
  logic             w_key_clr;
  logic             w_key_inc;
  mem_owner_t       w_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_key   <= '0;
    end else begin
      r_state <= w_next;
      if (w_key_clr)
        r_key <= '0;
      else if (w_key_inc)
        r_key <= r_key + 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_key_clr  = 1'b0;
    w_key_inc  = 1'b0;
    init_start = 1'b0;
    ksa_start  = 1'b0;
    prga_start = 1'b0;
    case (r_state)
      IDLE, FOUND, FAIL: begin
        if (sig_start) begin
          w_next    = INIT_GO;
          w_key_clr = 1'b1;
        end
      end
      INIT_GO: begin
        init_start = 1'b1;
        w_next     = INIT_WAIT;
      end
      INIT_WAIT: if (init_done) w_next = KSA_GO;
      KSA_GO: begin
        ksa_start = 1'b1;
        w_next    = KSA_WAIT;
      end
      KSA_WAIT: if (ksa_done) w_next = PRGA_GO;
      PRGA_GO: begin
        prga_start = 1'b1;
        w_next     = PRGA_WAIT;
      end
      PRGA_WAIT: if (prga_done) w_next = CHECK;
      // The checker has had one full cycle to settle on the last byte by now.
      CHECK: begin
        if (msg_ok)
          w_next = FOUND;
        else if (r_key == KEY_LAST)
          w_next = FAIL;
        else
          w_next = NEXT_KEY;
      end
      NEXT_KEY: begin
        w_key_inc = 1'b1;
        w_next    = INIT_GO;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_owner    = owner_of(r_state);
  assign secret_key = r_key;
  assign busy       = (r_state != IDLE) && (r_state != FOUND) && (r_state != FAIL);
  assign found      = (r_state == FOUND);
  assign fail       = (r_state == FAIL);

  s_mem_port_mux u_mux (
    .i_sel       (w_owner),
    .i_init_addr (init_addr),
    .i_init_data (init_data),
    .i_init_wren (init_wren),
    .i_ksa_addr  (ksa_addr),
    .i_ksa_data  (ksa_data),
    .i_ksa_wren  (ksa_wren),
    .i_prga_addr (prga_addr),
    .i_prga_data (prga_data),
    .i_prga_wren (prga_wren),
    .o_addr      (mem_address),
    .o_data      (mem_data),
    .o_wren      (wren)
  );

endmodule

// File: tb/tb_rc4_phase_sched.sv
// Self-checking bench for rc4_phase_sched: stub phase blocks with programmable
// done latencies, a key-match checker stub, and a per-key timing/grant model.
module tb_rc4_phase_sched;

  localparam logic [23:0] TB_KEY_LAST = 24'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sig_start = 1'b0;
  logic        init_start, ksa_start, prga_start;
  logic        init_done, ksa_done, prga_done;
  logic [7:0]  init_addr = 8'h11, init_data = 8'hA1;
  logic [7:0]  ksa_addr  = 8'h22, ksa_data  = 8'hB2;
  logic [7:0]  prga_addr = 8'h33, prga_data = 8'hC3;
  logic        init_wren = 1'b1, ksa_wren = 1'b1, prga_wren = 1'b1;
  logic [7:0]  mem_address, mem_data;
  logic        wren;
  logic        msg_ok;
  logic [23:0] secret_key;
  logic        busy, found, fail;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int n_init = 0, n_ksa = 0, n_prga = 0;
  int t_ksa = 0, t_prga = 0;
  int          t_init_q[$];
  logic [23:0] key_q[$];

  int lat_init = 4, lat_ksa = 4, lat_prga = 4;
  int cnt_i = 0, cnt_k = 0, cnt_p = 0;
  logic done_i_stub = 1'b0, done_k_stub = 1'b0, done_p_stub = 1'b0;
  logic init_spur = 1'b0, ksa_spur = 1'b0, prga_spur = 1'b0;
  logic        ok_en = 1'b0;
  logic [23:0] ok_key = 24'd0;

  assign init_done = done_i_stub | init_spur;
  assign ksa_done  = done_k_stub | ksa_spur;
  assign prga_done = done_p_stub | prga_spur;
  assign msg_ok    = ok_en && (secret_key == ok_key);

  always #5 clk = ~clk;

  rc4_phase_sched #(.KEY_W(24), .KEY_LAST(TB_KEY_LAST)) dut (
    .clk(clk), .reset(reset), .sig_start(sig_start),
    .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
    .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
    .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
    .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wren(ksa_wren),
    .prga_addr(prga_addr), .prga_data(prga_data), .prga_wren(prga_wren),
    .mem_address(mem_address), .mem_data(mem_data), .wren(wren),
    .msg_ok(msg_ok), .secret_key(secret_key),
    .busy(busy), .found(found), .fail(fail)
  );

  // Pulse monitor plus phase stubs: a stub raises done exactly lat cycles
  // after the cycle in which it saw its start pulse.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (init_start) begin
        n_init++;
        t_init_q.push_back(cyc);
        key_q.push_back(secret_key);
      end
      if (ksa_start)  begin n_ksa++;  t_ksa  = cyc; end
      if (prga_start) begin n_prga++; t_prga = cyc; end
      done_i_stub = 1'b0;
      done_k_stub = 1'b0;
      done_p_stub = 1'b0;
      if (reset) begin
        cnt_i = 0; cnt_k = 0; cnt_p = 0;
      end else begin
        if (cnt_i == 1) done_i_stub = 1'b1;
        if (cnt_k == 1) done_k_stub = 1'b1;
        if (cnt_p == 1) done_p_stub = 1'b1;
        if (cnt_i > 0) cnt_i--;
        if (cnt_k > 0) cnt_k--;
        if (cnt_p > 0) cnt_p--;
        if (init_start) cnt_i = lat_init;
        if (ksa_start)  cnt_k = lat_ksa;
        if (prga_start) cnt_p = lat_prga;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    sig_start = 1'b1;
    tick();
    sig_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (found || fail) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    ok = found || fail;
  endtask

  task automatic test_reset();
    int k0, i0, p0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if ({busy, found, fail, wren} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/found/fail/wren=%b required 0000", {busy, found, fail, wren});
    end
    checks++;
    if ({mem_address, mem_data, secret_key} !== 40'd0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h key=%h required zeros", mem_address, mem_data, secret_key);
    end
    lat_init = 5; lat_ksa = 50; lat_prga = 5; ok_en = 1'b0;
    k0 = n_ksa;
    pulse_start();
    for (int i = 0; i < 100 && n_ksa == k0; i++) tick();
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1 || n_ksa != k0 + 1) begin
      errors++;
      $display("FAIL reset_setup: busy=%b ksa_pulses=%0d required busy=1 pulses=1", busy, n_ksa - k0);
    end
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, found, fail, wren, init_start, ksa_start, prga_start} !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_ksa: busy/found/fail/wren/starts=%b required 0", {busy, found, fail, wren, init_start, ksa_start, prga_start});
    end
    checks++;
    if ({mem_address, mem_data, secret_key} !== 40'd0) begin
      errors++;
      $display("FAIL reset_mid_bus: addr=%h data=%h key=%h required zeros", mem_address, mem_data, secret_key);
    end
    i0 = n_init; k0 = n_ksa; p0 = n_prga;
    repeat (80) tick();
    checks++;
    if (n_init != i0 || n_ksa != k0 || n_prga != p0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: extra pulses i/k/p=%0d/%0d/%0d busy=%b required 0/0/0 busy=0",
               n_init - i0, n_ksa - k0, n_prga - p0, busy);
    end
  endtask

  task automatic test_single_key();
    int i0, k0, p0, c0;
    bit ok;
    lat_init = 256; lat_ksa = 768; lat_prga = 900;
    ok_en = 1'b1; ok_key = 24'd0;
    i0 = n_init; k0 = n_ksa; p0 = n_prga;
    pulse_start();
    c0 = cyc;
    checks++;
    if (init_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: init_start=%b busy=%b required 1 1", init_start, busy);
    end
    wait_end(3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout: no found/fail within budget, required found");
    end
    checks++;
    if (cyc - c0 != lat_init + lat_ksa + lat_prga + 4) begin
      errors++;
      $display("FAIL single_latency: cycles=%0d required %0d", cyc - c0, lat_init + lat_ksa + lat_prga + 4);
    end
    checks++;
    if (n_init - i0 != 1 || n_ksa - k0 != 1 || n_prga - p0 != 1) begin
      errors++;
      $display("FAIL single_pulses: i/k/p=%0d/%0d/%0d required 1/1/1", n_init - i0, n_ksa - k0, n_prga - p0);
    end
    checks++;
    if ({found, fail, busy, wren} !== 4'b1000 || secret_key !== 24'd0) begin
      errors++;
      $display("FAIL single_result: found/fail/busy/wren=%b key=%0d required 1000 key=0", {found, fail, busy, wren}, secret_key);
    end
  endtask

  task automatic test_key_walk();
    int per, n;
    bit ok;
    lat_init = $urandom_range(1, 12); lat_ksa = $urandom_range(1, 12); lat_prga = $urandom_range(1, 12);
    per = lat_init + lat_ksa + lat_prga + 5;
    ok_en = 1'b1; ok_key = 24'd5;
    t_init_q.delete(); key_q.delete();
    pulse_start();
    wait_end(2000, ok);
    checks++;
    if (!ok || found !== 1'b1 || secret_key !== 24'd5) begin
      errors++;
      $display("FAIL walk_result: ended=%0d found=%b key=%0d required found key=5", ok, found, secret_key);
    end
    checks++;
    if (t_init_q.size() != 6) begin
      errors++;
      $display("FAIL walk_count: init pulses=%0d required 6", t_init_q.size());
    end
    n = (t_init_q.size() < 6) ? t_init_q.size() : 6;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (key_q[i] !== 24'(i)) begin
        errors++;
        $display("FAIL walk_key%0d: key=%0d required %0d", i, key_q[i], i);
      end
      if (i > 0) begin
        checks++;
        if (t_init_q[i] - t_init_q[i-1] != per) begin
          errors++;
          $display("FAIL walk_period%0d: cycles=%0d required %0d", i, t_init_q[i] - t_init_q[i-1], per);
        end
      end
    end
  endtask

  task automatic test_exhaustion();
    bit ok;
    lat_init = $urandom_range(1, 6); lat_ksa = $urandom_range(1, 6); lat_prga = $urandom_range(1, 6);
    ok_en = 1'b0;
    t_init_q.delete(); key_q.delete();
    pulse_start();
    wait_end(2000, ok);
    repeat (4) tick();
    checks++;
    if (!ok || {fail, found, busy} !== 3'b100) begin
      errors++;
      $display("FAIL exhaust_flags: ended=%0d fail/found/busy=%b required 100", ok, {fail, found, busy});
    end
    checks++;
    if (secret_key !== TB_KEY_LAST || t_init_q.size() != int'(TB_KEY_LAST) + 1) begin
      errors++;
      $display("FAIL exhaust_key: key=%0d keys_tried=%0d required key=%0d tried=%0d",
               secret_key, t_init_q.size(), TB_KEY_LAST, int'(TB_KEY_LAST) + 1);
    end
    ok_en = 1'b1; ok_key = 24'd0;
    pulse_start();
    checks++;
    if (init_start !== 1'b1 || secret_key !== 24'd0 || fail !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart: init_start=%b key=%0d fail=%b busy=%b required 1 0 0 1", init_start, secret_key, fail, busy);
    end
    wait_end(500, ok);
    checks++;
    if (!ok || found !== 1'b1 || secret_key !== 24'd0) begin
      errors++;
      $display("FAIL restart_result: found=%b key=%0d required found key=0", found, secret_key);
    end
  endtask

  task automatic test_found_at_last();
    bit ok;
    lat_init = 2; lat_ksa = 3; lat_prga = 1;
    ok_en = 1'b1; ok_key = TB_KEY_LAST;
    pulse_start();
    wait_end(1000, ok);
    checks++;
    if (!ok || {found, fail} !== 2'b10 || secret_key !== TB_KEY_LAST) begin
      errors++;
      $display("FAIL last_key_found: found/fail=%b key=%0d required 10 key=%0d", {found, fail}, secret_key, TB_KEY_LAST);
    end
  endtask

  task automatic test_grant_isolation();
    int owner, n_own[4], seen_found, bad;
    logic [7:0] ea, ed;
    logic       ew;
    lat_init = $urandom_range(2, 6); lat_ksa = $urandom_range(2, 6); lat_prga = $urandom_range(2, 6);
    ok_en = 1'b1; ok_key = 24'd1;
    owner = 0; seen_found = 0; bad = 0;
    for (int j = 0; j < 4; j++) n_own[j] = 0;
    checks++;
    if (wren !== 1'b0 || mem_address !== 8'h00) begin
      errors++;
      $display("FAIL grant_idle: wren=%b addr=%h required 0 00", wren, mem_address);
    end
    sig_start = 1'b1;
    for (int i = 0; i < 400 && seen_found < 3; i++) begin
      tick();
      sig_start = 1'b0;
      if (init_start) owner = 1;
      if (ksa_start)  owner = 2;
      if (prga_start) owner = 3;
      case (owner)
        1: begin ea = init_addr; ed = init_data; ew = init_wren; end
        2: begin ea = ksa_addr;  ed = ksa_data;  ew = ksa_wren;  end
        3: begin ea = prga_addr; ed = prga_data; ew = prga_wren; end
        default: begin ea = 8'h00; ed = 8'h00; ew = 1'b0; end
      endcase
      n_own[owner]++;
      checks++;
      if (mem_address !== ea || mem_data !== ed || wren !== ew) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL grant_cycle%0d: addr=%h data=%h wren=%b required %h %h %b", i, mem_address, mem_data, wren, ea, ed, ew);
      end
      if ((owner == 1 && init_done) || (owner == 2 && ksa_done) || (owner == 3 && prga_done)) owner = 0;
      if (found) seen_found++;
    end
    checks++;
    if (n_own[1] != 2 * (lat_init + 1) || n_own[2] != 2 * (lat_ksa + 1) || n_own[3] != 2 * (lat_prga + 1)) begin
      errors++;
      $display("FAIL grant_windows: init/ksa/prga cycles=%0d/%0d/%0d required %0d/%0d/%0d",
               n_own[1], n_own[2], n_own[3], 2 * (lat_init + 1), 2 * (lat_ksa + 1), 2 * (lat_prga + 1));
    end
    checks++;
    if (seen_found < 3 || secret_key !== 24'd1) begin
      errors++;
      $display("FAIL grant_result: found_cycles=%0d key=%0d required 3 key=1", seen_found, secret_key);
    end
  endtask

  task automatic test_spurious();
    int i0, k0, p0, c0, off, t_found;
    lat_init = 30; lat_ksa = 20; lat_prga = 25;
    ok_en = 1'b1; ok_key = 24'd0;
    i0 = n_init; k0 = n_ksa; p0 = n_prga;
    pulse_start();
    c0 = cyc;
    t_found = -1;
    for (int i = 0; i < 200 && t_found < 0; i++) begin
      tick();
      off = cyc - c0;
      ksa_spur = 1'b0; prga_spur = 1'b0; init_spur = 1'b0; sig_start = 1'b0;
      if (off == 10 || off == lat_init) begin
        ksa_spur = 1'b1; prga_spur = 1'b1;
      end
      if (off == lat_init + lat_ksa + 8) begin
        sig_start = 1'b1; init_spur = 1'b1; ksa_spur = 1'b1;
      end
      if (found) t_found = off;
    end
    ksa_spur = 1'b0; prga_spur = 1'b0; init_spur = 1'b0; sig_start = 1'b0;
    checks++;
    if (t_ksa - c0 != lat_init + 1) begin
      errors++;
      $display("FAIL spur_ksa_time: offset=%0d required %0d", t_ksa - c0, lat_init + 1);
    end
    checks++;
    if (t_prga - c0 != lat_init + lat_ksa + 2) begin
      errors++;
      $display("FAIL spur_prga_time: offset=%0d required %0d", t_prga - c0, lat_init + lat_ksa + 2);
    end
    checks++;
    if (n_init - i0 != 1 || n_ksa - k0 != 1 || n_prga - p0 != 1) begin
      errors++;
      $display("FAIL spur_pulses: i/k/p=%0d/%0d/%0d required 1/1/1", n_init - i0, n_ksa - k0, n_prga - p0);
    end
    checks++;
    if (t_found != lat_init + lat_ksa + lat_prga + 4 || secret_key !== 24'd0) begin
      errors++;
      $display("FAIL spur_found: offset=%0d key=%0d required %0d key=0", t_found, secret_key, lat_init + lat_ksa + lat_prga + 4);
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_key_walk();
    test_exhaustion();
    test_found_at_last();
    test_grant_isolation();
    test_spurious();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
